// File: rtl/key_schedule.sv
// key_schedule
// ------------
// Sequential AES-128 key schedule. A 128-bit cipher key is taken over a
// valid/ready handshake. One expandKey round is then applied per clock until
// all 11 round keys sit in an internal register file. The cipher datapath
// reads that file by round index through a registered read port.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous, active-low reset
//   key_in       cipher key, bits [127:96] are word w0
//   key_valid    key_in is valid; accepted when key_valid && key_ready
//   key_ready    high in IDLE, a new key can be accepted
//   busy         high while the expansion is running
//   done         one-cycle pulse after round key 10 has been written
//   table_valid  all 11 stored round keys belong to the last accepted key
//   rk_addr      round-key index to read, 0..10 (11..15 read as zero)
//   rk_out       registered round key for rk_addr, one cycle of latency
module key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         table_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_out
);

    typedef enum logic {IDLE, EXPAND} state_t;

    // AES forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state;
    state_t         state_next;
    logic [3:0]     round;
    logic [127:0]   cur;
    logic [127:0]   rk [0:10];
    logic [127:0]   next_key;
    logic [127:0]   rd_sel;
    logic           accept;
    logic           last;

    // Byte b lives at bit offset (255-b)*8, and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subBytes32(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [7:0] count);
        logic [7:0] rc;
        case (count)
            8'd1:    rc = 8'h01;
            8'd2:    rc = 8'h02;
            8'd3:    rc = 8'h04;
            8'd4:    rc = 8'h08;
            8'd5:    rc = 8'h10;
            8'd6:    rc = 8'h20;
            8'd7:    rc = 8'h40;
            8'd8:    rc = 8'h80;
            8'd9:    rc = 8'h1b;
            8'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    // One AES-128 expansion round: the last word is rotated, substituted and
    // mixed with rcon, and then the XOR ripples through all four words.
    function automatic logic [127:0] expandKey(input logic [127:0] in,
                                               input logic [7:0]   count);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = subBytes32({in[23:0], in[31:24]}) ^ rcon(count);
        n0 = in[127:96] ^ t;
        n1 = in[95:64]  ^ n0;
        n2 = in[63:32]  ^ n1;
        n3 = in[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign next_key = expandKey(cur, {4'b0000, round});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. key_valid is only looked at in IDLE,
    // so a key offered during an expansion waits until the block is idle again.
    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    accept     = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                if (round == 4'd10) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Expansion datapath. Entries are overwritten in ascending order, so a
    // table being rebuilt holds a mix of old and new keys until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round       <= 4'd0;
            cur         <= '0;
            done        <= 1'b0;
            table_valid <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                rk[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (accept) begin
                rk[0]       <= key_in;
                cur         <= key_in;
                round       <= 4'd1;
                table_valid <= 1'b0;
            end else if (busy) begin
                rk[round] <= next_key;
                cur       <= next_key;
                round     <= round + 4'd1;
                if (last) begin
                    done        <= 1'b1;
                    table_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (rk_addr <= 4'd10) begin
            rd_sel = rk[rk_addr];
        end
    end

    // Registered read port. It samples the pre-edge table, so an entry
    // written on the same edge is returned with its old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out <= '0;
        end else begin
            rk_out <= rd_sel;
        end
    end

endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule
// ---------------
// Self-checking bench for key_schedule. The reference model is a plain
// FIPS-197 word-array key expansion. It derives its S-box from the GF(2^8)
// inverse and the affine transform, so it does not reuse the design's table.
module tb_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         table_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_out;

    int checks_total;
    int checks_passed;

    logic [7:0]   sb      [256];
    logic [127:0] ref_tab [11];
    logic [127:0] exp_tab [11];

    key_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .busy        (busy),
        .done        (done),
        .table_valid (table_valid),
        .rk_addr     (rk_addr),
        .rk_out      (rk_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the field inverse (a^254, which maps 0 to 0) and the affine map.
    function automatic void buildSbox();
        logic [7:0] r;
        for (int a = 0; a < 256; a++) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, 8'(a));
            sb[a] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                      ^ {r[3:0], r[7:4]} ^ 8'h63;
        end
    endfunction

    // FIPS-197 expansion over 44 words into ref_tab.
    function automatic void buildRef(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            ref_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endfunction

    // Loads one key and follows its expansion edge by edge. rk_addr tracks
    // the entry written on each edge, so every read must show the old value.
    // With hold set, key_valid stays high carrying nxt during the expansion.
    task automatic applyStimulus(input logic [127:0] key, input bit hold,
                                 input logic [127:0] nxt);
        buildRef(key);
        @(negedge clk);
        key_in    = key;
        key_valid = 1'b1;
        rk_addr   = 4'd0;
        checkOutput("ready_before_accept", key_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("busy_after_accept", busy, 1);
        checkOutput("ready_after_accept", key_ready, 0);
        checkOutput("tv_after_accept", table_valid, 0);
        checkOutput("done_after_accept", done, 0);
        checkOutput("rbw_rk0", rk_out, exp_tab[0]);
        if (hold) begin
            key_in = nxt;
        end else begin
            key_valid = 1'b0;
            key_in    = {$urandom, $urandom, $urandom, $urandom};
        end
        rk_addr = 4'd1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("done_edge%0d", k), done, (k == 10));
            checkOutput($sformatf("tv_edge%0d", k), table_valid, (k == 10));
            checkOutput($sformatf("busy_edge%0d", k), busy, (k < 10));
            checkOutput($sformatf("rbw_rk%0d", k), rk_out, exp_tab[k]);
            rk_addr = (k < 10) ? 4'(k + 1) : 4'd0;
        end
        checkOutput("ready_after_done", key_ready, 1);
        for (int r = 0; r < 11; r++) exp_tab[r] = ref_tab[r];
    endtask

    task automatic readCheck(input logic [3:0] addr, input logic [127:0] exp,
                             input string tag);
        @(negedge clk);
        rk_addr = addr;
        @(posedge clk);
        #1;
        checkOutput(tag, rk_out, exp);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            readCheck(4'(a), (a < 11) ? exp_tab[a] : 128'h0,
                      $sformatf("sweep_addr%0d", a));
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_addr   = 4'd0;
        buildSbox();
        for (int r = 0; r < 11; r++) exp_tab[r] = '0;
        #1;
        checkOutput("rst_ready", key_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tv", table_valid, 0);
        checkOutput("rst_rkout", rk_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] FIPS-197 key");
        applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, '0);
        readCheck(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        readCheck(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        sweep();

        $display("[TB] all-zero key");
        applyStimulus(128'h0, 1'b0, '0);
        readCheck(4'd0, 128'h0, "zero_rk0");
        readCheck(4'd1, 128'h62636363626363636263636362636363, "zero_rk1");
        readCheck(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        $display("[TB] key_valid held through an expansion");
        begin
            logic [127:0] ka;
            logic [127:0] kb;
            ka = {$urandom, $urandom, $urandom, $urandom};
            kb = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(ka, 1'b1, kb);
            applyStimulus(kb, 1'b0, '0);
            sweep();
        end

        $display("[TB] random keys");
        for (int n = 0; n < 3; n++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
            sweep();
        end

        $display("[TB] reset in mid-expansion");
        @(negedge clk);
        key_in    = {$urandom, $urandom, $urandom, 32'h00000001};
        key_valid = 1'b1;
        rk_addr   = 4'd0;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_before_reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", key_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_tv", table_valid, 0);
        checkOutput("midrst_rkout", rk_out, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("done_in_reset", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("done_after_reset", done, 0);
            checkOutput("busy_after_reset", busy, 0);
        end
        for (int r = 0; r < 11; r++) exp_tab[r] = '0;
        sweep();
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        sweep();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
